// File: rtl/vie_if_buf_stage_if.sv
// Fetch-stage bus bundle: decode handshake, redirect request and inst-SRAM port.
// The master side is the fetch stage; the slave side is the decode/SRAM environment.
interface vie_if_buf_stage_if;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  ds_allowin, br_taken, br_target, inst_sram_rdata,
        output fs_to_ds_valid, fs_pc, fs_inst,
               inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ds_allowin, br_taken, br_target, inst_sram_rdata,
        input  fs_to_ds_valid, fs_pc, fs_inst,
               inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/vie_if_buf_stage.sv
// Instruction-fetch stage with a decoupling instruction buffer.
// One inst-SRAM read per cycle (1-cycle latency); returned {pc,inst} pairs are
// queued in an IBUF_DEPTH-entry FIFO and handed to decode from the FIFO head.
// Branch redirect optionally retains one delay-slot instruction.
module vie_if_buf_stage #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter int          IBUF_DEPTH = 4,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    vie_if_buf_stage_if.master     fs
);

    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    logic [31:0]   pc_q   [IBUF_DEPTH];
    logic [31:0]   inst_q [IBUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          inflight;
    logic [31:0]   infl_pc;
    logic [31:0]   pf_pc;

    logic          valid;
    logic          pop;
    logic          redirect;
    logic          keep;
    logic          keep_head;
    logic          ds_fetch;
    logic          kill;
    logic          push;
    logic [OW-1:0] occ;
    logic          credit;
    logic          fetch_en;
    logic [31:0]   fetch_addr;

    // Handshake, credit and redirect decisions for the current cycle.
    always_comb begin
        valid      = (count != '0);
        pop        = valid && fs.ds_allowin;
        redirect   = fs.br_taken && !reset;
        keep       = DELAY_SLOT && !pop;
        // Delay slot already buffered: keep only the head entry.
        keep_head  = keep && (count != '0);
        // Delay slot not yet requested: fetch it now from pf_pc, then go to target.
        ds_fetch   = keep && (count == '0) && !inflight;
        kill       = redirect && (!keep || keep_head);
        push       = !reset && inflight && !kill;
        // Outstanding request counts against the buffer so its data always has a slot.
        occ        = OW'(count) + OW'(inflight) - OW'(pop);
        credit     = (occ < OW'(IBUF_DEPTH));
        fetch_en   = !reset && (redirect || credit);
        fetch_addr = (redirect && !ds_fetch) ? fs.br_target : pf_pc;
    end

    assign fs.fs_to_ds_valid  = valid;
    assign fs.fs_pc           = pc_q[rd_ptr];
    assign fs.fs_inst         = inst_q[rd_ptr];
    assign fs.inst_sram_en    = fetch_en;
    assign fs.inst_sram_wen   = 4'h0;
    assign fs.inst_sram_addr  = fetch_addr;
    assign fs.inst_sram_wdata = 32'h0;

    // Buffer storage: capture the returning instruction with its fetch PC.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_q[wr_ptr]   <= infl_pc;
            inst_q[wr_ptr] <= fs.inst_sram_rdata;
        end
    end

    // Fetch PC, outstanding-request tracking and FIFO occupancy/pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            infl_pc  <= RESET_PC;
            pf_pc    <= RESET_PC;
        end else begin
            inflight <= fetch_en;
            if (fetch_en) begin
                infl_pc <= fetch_addr;
                pf_pc   <= ds_fetch && redirect ? fs.br_target : fetch_addr + 32'd4;
            end
            if (redirect && !keep) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else if (redirect && keep_head) begin
                count  <= CW'(1);
                wr_ptr <= rd_ptr + PW'(1);
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vie_if_buf_stage.sv
// Directed bench for vie_if_buf_stage: a per-cycle vector table on a
// DELAY_SLOT=1 instance plus a hand sequence on a DELAY_SLOT=0 instance.
// Inst SRAM model returns mem[a] = a, so the expected inst equals the pc.
module tb_vie_if_buf_stage;

    localparam logic [31:0] RP = 32'hbfc00000;

    logic clock = 1'b0;
    logic rst1;
    logic rst0;

    vie_if_buf_stage_if b1 ();
    vie_if_buf_stage_if b0 ();

    vie_if_buf_stage #(.RESET_PC(RP), .IBUF_DEPTH(4), .DELAY_SLOT(1'b1)) dut1 (
        .clock (clock),
        .reset (rst1),
        .fs    (b1)
    );

    vie_if_buf_stage #(.RESET_PC(RP), .IBUF_DEPTH(4), .DELAY_SLOT(1'b0)) dut0 (
        .clock (clock),
        .reset (rst0),
        .fs    (b0)
    );

    always #5 clock = ~clock;

    // Inst SRAM models: one-cycle read latency, data = address, holds when idle.
    always @(posedge clock) begin
        if (b1.inst_sram_en) b1.inst_sram_rdata <= b1.inst_sram_addr;
        if (b0.inst_sram_en) b0.inst_sram_rdata <= b0.inst_sram_addr;
    end

    typedef struct {
        bit          rst;
        bit          al;
        bit          br;
        logic [31:0] tgt;
        bit          en;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tv [$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t v(bit rst, bit al, bit br, logic [31:0] tgt_off,
                               bit en, logic [31:0] addr_off, bit valid, logic [31:0] pc_off);
        vec_t r;
        r.rst   = rst;
        r.al    = al;
        r.br    = br;
        r.tgt   = RP + tgt_off;
        r.en    = en;
        r.addr  = RP + addr_off;
        r.valid = valid;
        r.pc    = RP + pc_off;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        b1.inst_sram_rdata = 32'hdeadbeef;
        b0.inst_sram_rdata = 32'hdeadbeef;
        b1.ds_allowin = 1'b1; b1.br_taken = 1'b0; b1.br_target = 32'h0;
        b0.ds_allowin = 1'b1; b0.br_taken = 1'b0; b0.br_target = 32'h0;
        rst1 = 1'b1;
        rst0 = 1'b1;

        //         rst al br tgt     en addr    vld pc
        tv.push_back(v(1, 1, 0, 0,      0, 'h0,   0, 0));      // reset state
        tv.push_back(v(0, 1, 0, 0,      1, 'h0,   0, 0));      // first fetch
        tv.push_back(v(0, 1, 0, 0,      1, 'h4,   0, 0));
        tv.push_back(v(0, 1, 0, 0,      1, 'h8,   1, 'h0));    // valid two cycles later
        tv.push_back(v(0, 0, 0, 0,      1, 'hC,   1, 'h4));    // decode stalls
        tv.push_back(v(0, 0, 0, 0,      1, 'h10,  1, 'h4));
        tv.push_back(v(0, 0, 0, 0,      0, 'h14,  1, 'h4));    // no credit
        tv.push_back(v(0, 0, 0, 0,      0, 'h14,  1, 'h4));    // full, pf_pc frozen
        tv.push_back(v(0, 0, 0, 0,      0, 'h14,  1, 'h4));
        tv.push_back(v(0, 1, 0, 0,      1, 'h14,  1, 'h4));    // drain in order
        tv.push_back(v(0, 1, 0, 0,      1, 'h18,  1, 'h8));
        tv.push_back(v(0, 1, 0, 0,      1, 'h1C,  1, 'hC));
        tv.push_back(v(0, 0, 1, 'h100,  1, 'h100, 1, 'h10));   // redirect, keep head
        tv.push_back(v(0, 1, 0, 0,      1, 'h104, 1, 'h10));
        tv.push_back(v(0, 1, 0, 0,      1, 'h108, 1, 'h100));  // target right after slot
        tv.push_back(v(0, 1, 0, 0,      1, 'h10C, 1, 'h104));
        tv.push_back(v(0, 0, 0, 0,      1, 'h110, 1, 'h108));
        tv.push_back(v(0, 0, 0, 0,      1, 'h114, 1, 'h108));
        tv.push_back(v(0, 1, 1, 'h200,  1, 'h200, 1, 'h108));  // redirect with pop: flush
        tv.push_back(v(0, 1, 1, 'h300,  1, 'h300, 0, 0));      // empty, inflight slot kept
        tv.push_back(v(0, 1, 0, 0,      1, 'h304, 1, 'h200));
        tv.push_back(v(0, 0, 0, 0,      1, 'h308, 1, 'h300));
        tv.push_back(v(0, 0, 0, 0,      1, 'h30C, 1, 'h300));
        tv.push_back(v(1, 1, 1, 'h500,  0, 'h310, 1, 'h300));  // reset, count=3 + inflight
        tv.push_back(v(0, 1, 1, 'h400,  1, 'h0,   0, 0));      // empty, idle: slot from pf_pc
        tv.push_back(v(0, 1, 0, 0,      1, 'h400, 0, 0));
        tv.push_back(v(0, 1, 0, 0,      1, 'h404, 1, 'h0));    // stale rdata absent
        tv.push_back(v(0, 1, 0, 0,      1, 'h408, 1, 'h400));

        repeat (2) @(posedge clock);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clock);
            rst1         = tv[i].rst;
            b1.ds_allowin = tv[i].al;
            b1.br_taken  = tv[i].br;
            b1.br_target = tv[i].tgt;
            #1;
            chk($sformatf("row%0d en", i),    32'(b1.inst_sram_en),   32'(tv[i].en));
            chk($sformatf("row%0d addr", i),  b1.inst_sram_addr,      tv[i].addr);
            chk($sformatf("row%0d valid", i), 32'(b1.fs_to_ds_valid), 32'(tv[i].valid));
            if (tv[i].valid) begin
                chk($sformatf("row%0d pc", i),   b1.fs_pc,   tv[i].pc);
                chk($sformatf("row%0d inst", i), b1.fs_inst, tv[i].pc);
            end
        end
        chk("wen", 32'(b1.inst_sram_wen), 32'h0);
        chk("wdata", b1.inst_sram_wdata, 32'h0);

        // DELAY_SLOT=0: redirect while a read is in flight drops its data.
        @(negedge clock);
        rst0 = 1'b0;
        b0.ds_allowin = 1'b1;
        b0.br_taken = 1'b0;
        #1;
        chk("ds0 first en", 32'(b0.inst_sram_en), 32'h1);
        chk("ds0 first addr", b0.inst_sram_addr, RP);
        @(negedge clock);
        b0.br_taken = 1'b1;
        b0.br_target = RP + 32'h80;
        #1;
        chk("ds0 br en", 32'(b0.inst_sram_en), 32'h1);
        chk("ds0 br addr", b0.inst_sram_addr, RP + 32'h80);
        chk("ds0 br valid", 32'(b0.fs_to_ds_valid), 32'h0);
        @(negedge clock);
        b0.br_taken = 1'b0;
        #1;
        chk("ds0 killed valid", 32'(b0.fs_to_ds_valid), 32'h0);
        chk("ds0 next addr", b0.inst_sram_addr, RP + 32'h84);
        @(negedge clock);
        #1;
        chk("ds0 tgt valid", 32'(b0.fs_to_ds_valid), 32'h1);
        chk("ds0 tgt pc", b0.fs_pc, RP + 32'h80);
        chk("ds0 tgt inst", b0.fs_inst, RP + 32'h80);
        @(negedge clock);
        #1;
        chk("ds0 seq pc", b0.fs_pc, RP + 32'h84);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
